// File: rtl/ted_pi_loop_filter_if.sv
// ted_pi_loop_filter_if: TED error strobe in, NCO control word and loop status out
// Ports (signals): e_in/e_val error strobe, freeze/clear loop controls,
//   ctrl_o/ctrl_val_o control word strobe, lock_o lock status, int_sat_o integrator clamp flag
interface ted_pi_loop_filter_if #(
   parameter int WE = 18,
   parameter int WC = 24
);
   logic signed [WE-1:0] e_in;
   logic                 e_val;
   logic                 freeze;
   logic                 clear;
   logic signed [WC-1:0] ctrl_o;
   logic                 ctrl_val_o;
   logic                 lock_o;
   logic                 int_sat_o;
   modport master (output e_in, e_val, freeze, clear, input ctrl_o, ctrl_val_o, lock_o, int_sat_o);
   modport slave  (input e_in, e_val, freeze, clear, output ctrl_o, ctrl_val_o, lock_o, int_sat_o);
endinterface

// File: rtl/ted_pi_loop_filter.sv
// ted_pi_loop_filter: PI loop filter for symbol timing recovery with lock detector
// Ports: clk, reset_n (async active-low), bus (slave): e_in/e_val/freeze/clear in,
//   ctrl_o/ctrl_val_o/lock_o/int_sat_o out (all registered)
module ted_pi_loop_filter #(
   parameter int WE         = 18,
   parameter int WC         = 24,
   parameter int INT_W      = 32,
   parameter int KP_SHIFT   = 4,
   parameter int KI_SHIFT   = 8,
   parameter int LOCK_THR   = 1024,
   parameter int LOCK_CNT   = 64,
   parameter int UNLOCK_CNT = 16
) (
   input logic                 clk,
   input logic                 reset_n,
   ted_pi_loop_filter_if.slave bus
);
   localparam int PW  = WE + KP_SHIFT;
   localparam int IW  = INT_W - KI_SHIFT;
   localparam int MW  = PW > IW ? PW : IW;
   // widened to WC as well so the clamp constants always fit the sum
   localparam int SW  = (MW > WC ? MW : WC) + 1;
   localparam int CMX = LOCK_CNT > UNLOCK_CNT ? LOCK_CNT : UNLOCK_CNT;
   localparam int CW  = $clog2(CMX + 1);
   localparam logic signed [INT_W-1:0] IMAX  = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic signed [INT_W-1:0] IMIN  = {1'b1, {(INT_W-1){1'b0}}};
   localparam logic signed [SW-1:0]    CMAXV = {{(SW-WC+1){1'b0}}, {(WC-1){1'b1}}};
   localparam logic signed [SW-1:0]    CMINV = {{(SW-WC+1){1'b1}}, {(WC-1){1'b0}}};
   localparam logic [WE:0]             THR   = (WE+1)'(LOCK_THR);
   typedef enum logic {SEARCH, LOCKED} state_t;
   state_t                  state;
   logic signed [INT_W-1:0] integ, integ_new, i_shr;
   logic signed [INT_W:0]   isum;
   logic signed [SW-1:0]    p_term, i_term, sum;
   logic signed [WC-1:0]    ctrl_q, ctrl_c;
   logic [WE:0]             e_x, mag;
   logic [CW-1:0]           good_cnt, bad_cnt, good_inc, bad_inc;
   logic                    run, isat, good, ctrl_val_q, lock_q, sat_q;
   always_comb begin
      run       = bus.e_val & ~bus.freeze;
      isum      = {integ[INT_W-1], integ} + {{(INT_W+1-WE){bus.e_in[WE-1]}}, bus.e_in};
      // overflow of the INT_W-bit result shows as disagreeing top two bits
      isat      = isum[INT_W] ^ isum[INT_W-1];
      integ_new = !run ? integ : isat ? (isum[INT_W] ? IMIN : IMAX) : isum[INT_W-1:0];
      i_shr     = integ_new >>> KI_SHIFT;
      i_term    = {{(SW-IW){i_shr[IW-1]}}, i_shr[IW-1:0]};
      p_term    = {{(SW-WE){bus.e_in[WE-1]}}, bus.e_in} << KP_SHIFT;
      sum       = p_term + i_term;
      ctrl_c    = sum > CMAXV ? CMAXV[WC-1:0] : sum < CMINV ? CMINV[WC-1:0] : sum[WC-1:0];
      // one extra bit so the most negative error has a representable magnitude
      e_x       = {bus.e_in[WE-1], bus.e_in};
      mag       = e_x[WE] ? -e_x : e_x;
      good      = mag < THR;
      good_inc  = good_cnt == CW'(LOCK_CNT) ? good_cnt : good_cnt + CW'(1);
      bad_inc   = bad_cnt == CW'(UNLOCK_CNT) ? bad_cnt : bad_cnt + CW'(1);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= SEARCH;
         integ      <= '0;
         ctrl_q     <= '0;
         ctrl_val_q <= 1'b0;
         lock_q     <= 1'b0;
         sat_q      <= 1'b0;
         good_cnt   <= '0;
         bad_cnt    <= '0;
      end else if (bus.clear) begin
         state      <= SEARCH;
         integ      <= '0;
         ctrl_q     <= '0;
         ctrl_val_q <= 1'b0;
         lock_q     <= 1'b0;
         sat_q      <= 1'b0;
         good_cnt   <= '0;
         bad_cnt    <= '0;
      end else begin
         ctrl_val_q <= bus.e_val;
         if (bus.e_val) ctrl_q <= ctrl_c;
         if (run) begin
            integ <= integ_new;
            sat_q <= isat;
            if (state == SEARCH) begin
               good_cnt <= good ? good_inc : '0;
               if (good && good_inc == CW'(LOCK_CNT)) begin
                  state   <= LOCKED;
                  lock_q  <= 1'b1;
                  bad_cnt <= '0;
               end
            end else begin
               bad_cnt <= good ? '0 : bad_inc;
               if (!good && bad_inc == CW'(UNLOCK_CNT)) begin
                  state    <= SEARCH;
                  lock_q   <= 1'b0;
                  good_cnt <= '0;
               end
            end
         end
      end
   end
   assign bus.ctrl_o     = ctrl_q;
   assign bus.ctrl_val_o = ctrl_val_q;
   assign bus.lock_o     = lock_q;
   assign bus.int_sat_o  = sat_q;
endmodule

// File: doc/ted_pi_loop_filter.md
Name: ted_pi_loop_filter

Overview:
Proportional-integral loop filter for the symbol-timing recovery loop. It sits directly downstream of the Gardner TED: it consumes the TED error strobe and produces the registered control word for the phase-accumulator/NCO that generates sym_valid. A lock detector and integrator saturation flag are included for status and for loop-bandwidth switching.

Parameters:
WE, 18, TED error input width (signed)
WC, 24, control output width (signed)
INT_W, 32, integrator width (signed)
KP_SHIFT, 4, proportional gain = 2^KP_SHIFT (left shift)
KI_SHIFT, 8, integrator output scale = 2^-KI_SHIFT (arithmetic right shift)
LOCK_THR, 1024, |e| below this counts as a good sample
LOCK_CNT, 64, consecutive good samples needed to declare lock
UNLOCK_CNT, 16, consecutive bad samples needed to drop lock

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
e_in  in  WE  signed TED error
e_val  in  1  e_in valid strobe, single-cycle
freeze  in  1  hold integrator and lock FSM
clear  in  1  synchronous clear of integrator, counters and FSM
ctrl_o  out  WC  signed NCO control word
ctrl_val_o  out  1  ctrl_o valid strobe
lock_o  out  1  loop locked
int_sat_o  out  1  integrator currently clamped at a rail

Behaviour:
- Reset (async, reset_n=0): integ=0, ctrl_o=0, ctrl_val_o=0, lock_o=0, int_sat_o=0, FSM=SEARCH, counters=0.
- clear=1 has priority over e_val. It gives the same state as reset on the next edge, and ctrl_val_o=0 that cycle.
- On e_val=1 and freeze=0:
  - integ_new = sat_INT_W(integ + sext(e_in)).
  - int_sat_o=1 if the clamp was applied, else 0.
- On e_val=1 and freeze=1:
  - integ_new = integ. int_sat_o is unchanged.
  - The FSM and counters hold.
- ctrl computation:
  - ctrl = sat_WC( sext(e_in)<<KP_SHIFT + (integ_new >>> KI_SHIFT) ).
  - Sum is computed in max(WE+KP_SHIFT, INT_W-KI_SHIFT)+1 bits, with no intermediate wrap.
  - Clamp to [-2^(WC-1), 2^(WC-1)-1].
- Latency: ctrl_o and ctrl_val_o are registered, 1 clk after e_val. ctrl_val_o is high exactly one cycle per e_val.
- ctrl_o holds its last value between strobes.
- Back-to-back e_val on consecutive cycles is supported at full rate.
- Magnitude: |e| is computed in WE+1 bits, so |−2^(WE-1)| = 2^(WE-1), which is a bad sample.
- Lock FSM, evaluated only on e_val with freeze=0:
  - SEARCH (lock_o=0):
    - |e|<LOCK_THR: good_cnt++; otherwise good_cnt=0.
    - When good_cnt reaches LOCK_CNT: go to LOCKED, bad_cnt=0.
  - LOCKED (lock_o=1):
    - |e|>=LOCK_THR: bad_cnt++; otherwise bad_cnt=0.
    - When bad_cnt reaches UNLOCK_CNT: go to SEARCH, good_cnt=0.
- lock_o is registered and changes in the same cycle as ctrl_val_o for the triggering sample.
- Counters saturate and never wrap. Counter width is clog2(max(LOCK_CNT,UNLOCK_CNT)+1).
- freeze together with clear: clear wins.
- reset_n asserted mid-stream: outputs go to reset values immediately (asynchronously). The first e_val after deassertion is treated as the first sample.

Test Plan:
- Reset: hold reset_n=0 with e_val toggling -> ctrl_o=0, ctrl_val_o=0, lock_o=0, int_sat_o=0. Release, then one e_in=+256 -> next clk ctrl_o=4097 (256·16+1), ctrl_val_o pulses for 1 cycle.
- Step response: after the above, e_in=0 with e_val -> ctrl_o=1. e_in=-256 -> ctrl_o=-4096 (integ=0). Gaps between strobes leave ctrl_o unchanged.
- Freeze: integ=256, freeze=1, e_in=+512 -> ctrl_o=8193 (512·16+1) and integ stays 256. Release freeze, e_in=0 -> ctrl_o=1.
- Saturation: e_in=+131071 every cycle -> ctrl_o first 2097647, later clamps at 8388607. Continue to integ=2^31-1 -> int_sat_o=1, no wrap. Then e_in=-131072 -> int_sat_o=0, integ decreases.
- Lock: 63 samples of |e|=1000 -> lock_o=0. 64th -> lock_o=1 with its ctrl_val_o. One e=-1024 resets good_cnt if it occurs before lock. In LOCKED, 15 bad + 1 good + 16 bad -> lock_o drops on the 32nd.
- Clear and async reset: clear=1 with e_val=1 in LOCKED -> ctrl_val_o=0, lock_o=0, integ=0 next cycle. Pulse reset_n low between clock edges -> outputs zero before the next edge.
